// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one 4x4 unsigned multiplier between four
// requesters. The granted operand pair is multiplied combinationally and
// the product, with the requester id, lands in a one-entry output buffer.
module mult_rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [4*N_REQ-1:0]   req_a,
  input  logic [4*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_product,
  output logic [1:0]           res_id,
  output logic [7:0]           op_count
);

  logic [1:0] ptr_q, ptr_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_product_q, res_product_d;
  logic [1:0] res_id_q, res_id_d;
  logic [7:0] op_count_q, op_count_d;

  logic [1:0] gnt;
  logic       gnt_found;
  logic [1:0] cand;
  logic       can_accept;
  logic       accept;
  logic       drain;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_product;

  // Priority search starting at the round-robin pointer, wrapping modulo 4.
  always_comb begin
    gnt       = ptr_q;
    gnt_found = 1'b0;
    cand      = ptr_q;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = ptr_q + off[1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt       = cand;
        gnt_found = 1'b1;
      end
    end
  end

  // Handshake decode; the buffer can take a new result when empty or draining.
  always_comb begin
    can_accept = !res_valid_q || res_ready;
    accept     = can_accept && gnt_found && !rst;
    drain      = res_valid_q && res_ready;
    req_ready  = '0;
    if (accept) begin
      req_ready[gnt] = 1'b1;
    end
  end

  // Shared combinational multiplier, fed from the granted requester's lanes.
  always_comb begin
    mul_a       = req_a[{gnt, 2'b00} +: 4];
    mul_b       = req_b[{gnt, 2'b00} +: 4];
    mul_product = {4'b0000, mul_a} * {4'b0000, mul_b};
  end

  // Next-state: accept loads the buffer (even while draining), drain alone empties it.
  always_comb begin
    ptr_d         = ptr_q;
    res_valid_d   = res_valid_q;
    res_product_d = res_product_q;
    res_id_d      = res_id_q;
    op_count_d    = op_count_q;
    if (accept) begin
      res_valid_d   = 1'b1;
      res_product_d = mul_product;
      res_id_d      = gnt;
      ptr_d         = gnt + 2'd1;
    end else if (drain) begin
      res_valid_d = 1'b0;
    end
    if (drain) begin
      op_count_d = op_count_q + 8'd1;
    end
  end

  // State registers with synchronous reset; reset drops any buffered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= 2'd0;
      res_valid_q   <= 1'b0;
      res_product_q <= 8'd0;
      res_id_q      <= 2'd0;
      op_count_q    <= 8'd0;
    end else begin
      ptr_q         <= ptr_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
      res_id_q      <= res_id_d;
      op_count_q    <= op_count_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_product = res_product_q;
  assign res_id      = res_id_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Scoreboard bench for mult_rr_arbiter: the stimulus process pushes the
// hand-computed {id, product} for every accepted request, and a monitor pops
// and compares on every result drain.
module tb_mult_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_product;
  logic [1:0]  res_id;
  logic [7:0]  op_count;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb_q[$];

  mult_rr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_product(res_product),
    .res_id     (res_id),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  task automatic check_rdy(input string name, input logic [3:0] expected);
    #1;
    check(name, {28'd0, req_ready}, {28'd0, expected});
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] prod);
    sb_q.push_back({id, prod});
  endtask

  task automatic reset_pulse();
    rst       = 1'b1;
    req_valid = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every drain must match the oldest expected result.
  initial begin
    logic [9:0] exp_v;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got id=%0d prod=%0d expected none at %0t",
                   res_id, res_product, $time);
        end else begin
          exp_v = sb_q.pop_front();
          check("result_id", {30'd0, res_id}, {30'd0, exp_v[9:8]});
          check("result_product", {24'd0, res_product}, {24'd0, exp_v[7:0]});
        end
      end
    end
  end

  initial begin
    logic [3:0] a, b;
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    tick();
    tick();
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_product", {24'd0, res_product}, 32'd0);
    check("rst_id", {30'd0, res_id}, 32'd0);
    check("rst_op_count", {24'd0, op_count}, 32'd0);
    req_valid = 4'b1111;
    check_rdy("rst_no_ready", 4'b0000);
    req_valid = 4'b0000;
    rst = 1'b0;
    tick();

    // Single op: requester 2, 15*15.
    set_req(2, 4'd15, 4'd15);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    check_rdy("single_ready", 4'b0100);
    push(2'd2, 8'd225);
    tick();
    req_valid = 4'b0000;
    check("single_valid", {31'd0, res_valid}, 32'd1);
    check("single_product", {24'd0, res_product}, 32'd225);
    check("single_id", {30'd0, res_id}, 32'd2);
    tick();
    check("single_op_count", {24'd0, op_count}, 32'd1);
    check("single_empty", {31'd0, res_valid}, 32'd0);

    // Exhaustive sweep on requester 0, back to back.
    reset_pulse();
    for (int k = 0; k < 256; k++) begin
      a = k[7:4];
      b = k[3:0];
      set_req(0, a, b);
      req_valid = 4'b0001;
      check_rdy("sweep_ready", 4'b0001);
      push(2'd0, {4'd0, a} * {4'd0, b});
      if (k > 0) begin
        check("sweep_valid", {31'd0, res_valid}, 32'd1);
        check("sweep_op_count", {24'd0, op_count}, 32'(k - 1));
      end
      tick();
    end
    req_valid = 4'b0000;
    tick();
    check("sweep_wrap", {24'd0, op_count}, 32'd0);
    check("sweep_empty", {31'd0, res_valid}, 32'd0);

    // Fairness: all four valid, grants rotate 0,1,2,3,0,1.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      set_req(i, 4'(i + 1), 4'(i + 3));
    end
    req_valid = 4'b1111;
    begin
      logic [7:0] prods[4] = '{8'd3, 8'd8, 8'd15, 8'd24};
      logic [3:0] oh[4]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int c = 0; c < 6; c++) begin
        check_rdy("fair_ready", oh[c % 4]);
        push(2'(c % 4), prods[c % 4]);
        tick();
      end
    end
    req_valid = 4'b0000;
    tick();
    check("fair_op_count", {24'd0, op_count}, 32'd6);

    // Backpressure: pointer is at 2, so requester 3 wins first.
    res_ready = 1'b0;
    set_req(1, 4'd5, 4'd6);
    set_req(3, 4'd7, 4'd3);
    req_valid = 4'b1010;
    check_rdy("bp_first_ready", 4'b1000);
    push(2'd3, 8'd21);
    tick();
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      check_rdy("bp_stall_ready", 4'b0000);
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_product", {24'd0, res_product}, 32'd21);
      check("bp_id", {30'd0, res_id}, 32'd3);
      check("bp_op_count", {24'd0, op_count}, 32'd6);
      tick();
    end
    res_ready = 1'b1;
    check_rdy("bp_release_ready", 4'b0010);
    push(2'd1, 8'd30);
    tick();
    req_valid = 4'b0000;
    check("bp_no_bubble", {31'd0, res_valid}, 32'd1);
    check("bp_new_product", {24'd0, res_product}, 32'd30);
    check("bp_new_id", {30'd0, res_id}, 32'd1);
    check("bp_op_count_7", {24'd0, op_count}, 32'd7);
    tick();
    check("bp_op_count_8", {24'd0, op_count}, 32'd8);

    // Reset mid-op: buffered 7*9 is discarded, pointer returns to 0.
    res_ready = 1'b0;
    set_req(0, 4'd7, 4'd9);
    req_valid = 4'b0001;
    check_rdy("rmo_ready", 4'b0001);
    tick();
    check("rmo_full_product", {24'd0, res_product}, 32'd63);
    rst = 1'b1;
    set_req(0, 4'd1, 4'd1);
    check_rdy("rmo_rst_ready", 4'b0000);
    tick();
    check("rmo_valid", {31'd0, res_valid}, 32'd0);
    check("rmo_product", {24'd0, res_product}, 32'd0);
    check("rmo_id", {30'd0, res_id}, 32'd0);
    check("rmo_op_count", {24'd0, op_count}, 32'd0);
    check_rdy("rmo_rst_ready2", 4'b0000);
    tick();
    check("rmo_still_empty", {31'd0, res_valid}, 32'd0);
    rst = 1'b0;
    set_req(0, 4'd2, 4'd3);
    set_req(1, 4'd4, 4'd4);
    req_valid = 4'b0011;
    res_ready = 1'b1;
    check_rdy("rmo_ptr0_ready", 4'b0001);
    push(2'd0, 8'd6);
    tick();
    req_valid = 4'b0010;
    check_rdy("rmo_next_ready", 4'b0010);
    push(2'd1, 8'd16);
    tick();
    req_valid = 4'b0000;
    tick();

    // Pointer hold: grant 1, idle, then 0 and 2 together -> 2 first.
    set_req(1, 4'd3, 4'd3);
    req_valid = 4'b0010;
    check_rdy("ph_ready1", 4'b0010);
    push(2'd1, 8'd9);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    set_req(0, 4'd2, 4'd2);
    set_req(2, 4'd3, 4'd5);
    req_valid = 4'b0101;
    check_rdy("ph_ready2", 4'b0100);
    push(2'd2, 8'd15);
    tick();
    req_valid = 4'b0001;
    check_rdy("ph_ready0", 4'b0001);
    push(2'd0, 8'd4);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
